// File: rtl/spi_regfile_periph.sv
// SPI mode-0 peripheral with a small bank of control registers.
// Frames: R/W bit, address, data (MSB first); reads return data on CIPO.
module spi_regfile_periph #(
   parameter int NUM_REGS    = 5,
   parameter int ADDR_W      = 7,
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       sclk,
   input  logic                       copi,
   input  logic                       ncs,
   output logic                       cipo,
   output logic                       cipo_oe,
   output logic [NUM_REGS*DATA_W-1:0] regs_flat,
   output logic [NUM_REGS-1:0]        wr_strobe,
   output logic                       frame_err
);

   localparam int CNT_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [ADDR_W:0] LP_NREGS = (ADDR_W+1)'(NUM_REGS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_DONE
   } state_t;

   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_copi_sync;
   logic [SYNC_STAGES-1:0] r_ncs_sync;
   logic                   r_sclk_d;
   logic                   r_ncs_d;

   logic                   w_sclk_s;
   logic                   w_copi_s;
   logic                   w_ncs_s;
   logic                   w_sclk_rise;
   logic                   w_ncs_fall;
   logic                   w_ncs_rise;

   state_t                 r_state;
   state_t                 w_state_nxt;

   logic [CW-1:0]          r_cnt;
   logic [ADDR_W-1:0]      r_hdr;
   logic [ADDR_W-1:0]      r_addr;
   logic                   r_wr;
   logic                   r_in_range;
   logic [DATA_W-1:0]      r_wdata;
   logic [DATA_W-1:0]      r_rdsh;
   logic                   r_rd_pend;
   logic                   r_commit;
   logic                   r_over_seen;

   logic [NUM_REGS*DATA_W-1:0] r_regs;
   logic [NUM_REGS-1:0]        r_wr_strobe;
   logic                       r_frame_err;

   logic [ADDR_W:0]        w_hdr_full;
   logic [ADDR_W-1:0]      w_addr_new;
   logic                   w_wr_new;
   logic                   w_in_range_new;
   logic [DATA_W-1:0]      w_rd_sel;
   logic                   w_last_addr;
   logic                   w_last_data;
   logic                   w_abort;
   logic                   w_over;

   // Bring the SPI pins into the clk domain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sclk_sync <= '0;
         r_copi_sync <= '0;
         r_ncs_sync  <= '1;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
         r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
         r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
      end
   end

   assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
   assign w_copi_s = r_copi_sync[SYNC_STAGES-1];
   assign w_ncs_s  = r_ncs_sync[SYNC_STAGES-1];

   // Delayed copies for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sclk_d <= 1'b0;
         r_ncs_d  <= 1'b1;
      end else begin
         r_sclk_d <= w_sclk_s;
         r_ncs_d  <= w_ncs_s;
      end
   end

   // SCLK edges only count while nCS was already low, so a final
   // bit arriving together with the nCS rise is still accepted.
   assign w_sclk_rise = w_sclk_s & ~r_sclk_d & ~r_ncs_d;
   assign w_ncs_fall  = ~w_ncs_s & r_ncs_d;
   assign w_ncs_rise  = w_ncs_s & ~r_ncs_d;

   assign w_hdr_full     = {r_hdr, w_copi_s};
   assign w_addr_new     = w_hdr_full[ADDR_W-1:0];
   assign w_wr_new       = w_hdr_full[ADDR_W];
   assign w_in_range_new = ({1'b0, w_addr_new} < LP_NREGS);

   assign w_last_addr = w_sclk_rise && (r_cnt == CW'(ADDR_W));
   assign w_last_data = w_sclk_rise && (r_cnt == CW'(DATA_W-1));

   // Read mux for the address just captured; out of range reads 0
   always_comb begin
      w_rd_sel = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if ({1'b0, w_addr_new} == (ADDR_W+1)'(i)) begin
            w_rd_sel = r_regs[i*DATA_W +: DATA_W];
         end
      end
   end

   // Frame state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Frame sequencing, abort and over-length detection
   always_comb begin
      w_state_nxt = r_state;
      w_abort     = 1'b0;
      w_over      = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_ncs_fall) begin
               w_state_nxt = S_ADDR;
            end
         end
         S_ADDR: begin
            if (w_ncs_rise) begin
               w_abort     = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (w_last_addr) begin
               w_state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (w_last_data) begin
               w_state_nxt = S_DONE;
            end else if (w_ncs_rise) begin
               w_abort     = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         S_DONE: begin
            if (w_ncs_s) begin
               w_state_nxt = S_IDLE;
            end else if (w_sclk_rise && !r_over_seen) begin
               w_over = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Shift registers, counters and write commit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_hdr       <= '0;
         r_addr      <= '0;
         r_wr        <= 1'b0;
         r_in_range  <= 1'b0;
         r_wdata     <= '0;
         r_rdsh      <= '0;
         r_rd_pend   <= 1'b0;
         r_commit    <= 1'b0;
         r_over_seen <= 1'b0;
         r_regs      <= '0;
         r_wr_strobe <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_wr_strobe <= '0;
         r_frame_err <= w_abort | w_over;
         r_commit    <= 1'b0;
         r_rd_pend   <= 1'b0;

         if (r_commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
               if (r_addr == ADDR_W'(i)) begin
                  r_regs[i*DATA_W +: DATA_W] <= r_wdata;
                  r_wr_strobe[i]             <= 1'b1;
               end
            end
         end

         if (r_rd_pend) begin
            r_rdsh <= {r_rdsh[DATA_W-2:0], 1'b0};
         end

         unique case (r_state)
            S_IDLE: begin
               if (w_ncs_fall) begin
                  r_cnt       <= '0;
                  r_hdr       <= '0;
                  r_over_seen <= 1'b0;
               end
            end
            S_ADDR: begin
               if (w_sclk_rise && !w_abort) begin
                  r_hdr <= w_hdr_full[ADDR_W-1:0];
                  r_cnt <= r_cnt + CW'(1);
                  if (w_last_addr) begin
                     r_cnt      <= '0;
                     r_addr     <= w_addr_new;
                     r_wr       <= w_wr_new;
                     r_in_range <= w_in_range_new;
                     r_wdata    <= '0;
                     r_rdsh     <= w_wr_new ? '0 : w_rd_sel;
                  end
               end
            end
            S_DATA: begin
               if (w_sclk_rise && !w_abort) begin
                  r_wdata   <= {r_wdata[DATA_W-2:0], w_copi_s};
                  r_cnt     <= r_cnt + CW'(1);
                  r_rd_pend <= 1'b1;
                  if (w_last_data) begin
                     r_commit <= r_wr & r_in_range;
                  end
               end
            end
            S_DONE: begin
               if (w_over) begin
                  r_over_seen <= 1'b1;
               end
            end
            default: begin
               r_cnt <= '0;
            end
         endcase
      end
   end

   assign cipo_oe   = !r_wr && !w_ncs_s &&
                      ((r_state == S_DATA) || (r_state == S_DONE));
   assign cipo      = cipo_oe & r_rdsh[DATA_W-1];
   assign regs_flat = r_regs;
   assign wr_strobe = r_wr_strobe;
   assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_regfile_periph.sv
// Directed bench for spi_regfile_periph with write/read scoreboards.
// SPI controller is bit-banged from the clk domain at clk/16.
`timescale 1ns/1ps
module tb_spi_regfile_periph;

   logic        clk;
   logic        rst_n;
   logic        sclk;
   logic        copi;
   logic        ncs;
   logic        cipo;
   logic        cipo_oe;
   logic [39:0] regs_flat;
   logic [4:0]  wr_strobe;
   logic        frame_err;

   int n_tests;
   int n_fail;
   int err_cnt;

   logic [15:0] wq[$];
   logic [7:0]  rdq[$];
   logic [7:0]  mdl[5];

   spi_regfile_periph #(
      .NUM_REGS(5),
      .ADDR_W(7),
      .DATA_W(8),
      .SYNC_STAGES(2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .sclk(sclk),
      .copi(copi),
      .ncs(ncs),
      .cipo(cipo),
      .cipo_oe(cipo_oe),
      .regs_flat(regs_flat),
      .wr_strobe(wr_strobe),
      .frame_err(frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL timeout: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [39:0] mdl_flat();
      logic [39:0] f;
      f = '0;
      for (int i = 0; i < 5; i++) f[i*8 +: 8] = mdl[i];
      return f;
   endfunction

   // Strobe scoreboard and frame_err pulse counter
   always @(negedge clk) begin
      logic [15:0] e;
      if (rst_n && frame_err) err_cnt++;
      if (rst_n && wr_strobe != '0) begin
         if (wq.size() == 0) begin
            check("unexpected_strobe", 64'(wr_strobe), 64'd0);
         end else begin
            e = wq.pop_front();
            check("strobe_bit", 64'(wr_strobe), 64'(5'b1 << e[15:8]));
            check("commit_val", 64'(regs_flat[int'(e[15:8])*8 +: 8]),
                  64'(e[7:0]));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] w, input int pulses,
                       input bit raise, output logic [7:0] rd,
                       output bit oe_ok);
      bit oe_d;
      bit oe_a;
      oe_d = 1'b1;
      oe_a = 1'b0;
      rd   = '0;
      ncs  = 1'b0;
      tick(8);
      for (int i = 0; i < pulses; i++) begin
         copi = (i < 16) ? w[15-i] : 1'b0;
         tick(6);
         if (i >= 8 && i < 16) begin
            rd   = {rd[6:0], cipo};
            oe_d = oe_d & cipo_oe;
         end
         if (i < 8) oe_a = oe_a | cipo_oe;
         sclk = 1'b1;
         tick(8);
         sclk = 1'b0;
         tick(2);
      end
      tick(4);
      if (raise) begin
         ncs = 1'b1;
         tick(12);
      end
      oe_ok = oe_d & ~oe_a;
   endtask

   initial begin
      logic [7:0] rd;
      logic [7:0] rexp;
      bit         oe_ok;
      int         e0;

      n_tests = 0;
      n_fail  = 0;
      err_cnt = 0;
      for (int i = 0; i < 5; i++) mdl[i] = '0;
      rst_n = 1'b0;
      sclk  = 1'b0;
      copi  = 1'b0;
      ncs   = 1'b1;
      tick(5);
      check("rst_regs", 64'(regs_flat), 64'd0);
      check("rst_cipo", 64'(cipo), 64'd0);
      check("rst_cipo_oe", 64'(cipo_oe), 64'd0);
      check("rst_strobe", 64'(wr_strobe), 64'd0);
      check("rst_frame_err", 64'(frame_err), 64'd0);
      rst_n = 1'b1;
      tick(5);

      // Two in-range writes
      e0 = err_cnt;
      wq.push_back(16'h00A5);
      mdl[0] = 8'hA5;
      send(16'h80A5, 16, 1'b1, rd, oe_ok);
      wq.push_back(16'h043C);
      mdl[4] = 8'h3C;
      send(16'h843C, 16, 1'b1, rd, oe_ok);
      check("wr_regs", 64'(regs_flat), 64'(mdl_flat()));
      check("wr_reg0", 64'(regs_flat[7:0]), 64'hA5);
      check("wr_reg4", 64'(regs_flat[39:32]), 64'h3C);
      check("wr_no_err", 64'(err_cnt - e0), 64'd0);

      // Read back addr 4
      rdq.push_back(8'h3C);
      send(16'h045A, 16, 1'b1, rd, oe_ok);
      rexp = rdq.pop_front();
      check("rd_addr4", 64'(rd), 64'(rexp));
      check("rd_oe", 64'(oe_ok), 64'd1);
      check("rd_regs", 64'(regs_flat), 64'(mdl_flat()));
      check("idle_oe", 64'(cipo_oe), 64'd0);

      // Out-of-range write then read
      e0 = err_cnt;
      send(16'h89FF, 16, 1'b1, rd, oe_ok);
      rdq.push_back(8'h00);
      send(16'h09FF, 16, 1'b1, rd, oe_ok);
      rexp = rdq.pop_front();
      check("oor_rd", 64'(rd), 64'(rexp));
      check("oor_regs", 64'(regs_flat), 64'(mdl_flat()));
      check("oor_no_err", 64'(err_cnt - e0), 64'd0);

      // Aborted frame after 10 bits, then a full one
      e0 = err_cnt;
      send(16'h82FF, 10, 1'b1, rd, oe_ok);
      check("abort_err", 64'(err_cnt - e0), 64'd1);
      check("abort_regs", 64'(regs_flat), 64'(mdl_flat()));
      wq.push_back(16'h0211);
      mdl[2] = 8'h11;
      send(16'h8211, 16, 1'b1, rd, oe_ok);
      check("after_abort_reg2", 64'(regs_flat[23:16]), 64'h11);
      check("after_abort_err", 64'(err_cnt - e0), 64'd1);

      // Over-length frame of 20 pulses
      e0 = err_cnt;
      wq.push_back(16'h0155);
      mdl[1] = 8'h55;
      send(16'h8155, 20, 1'b1, rd, oe_ok);
      check("ovl_err", 64'(err_cnt - e0), 64'd1);
      check("ovl_regs", 64'(regs_flat), 64'(mdl_flat()));

      // Reset in the middle of a frame
      send(16'h8077, 12, 1'b0, rd, oe_ok);
      rst_n = 1'b0;
      for (int i = 0; i < 5; i++) mdl[i] = '0;
      tick(2);
      check("midrst_regs", 64'(regs_flat), 64'd0);
      check("midrst_oe", 64'(cipo_oe), 64'd0);
      ncs = 1'b1;
      tick(4);
      rst_n = 1'b1;
      tick(6);
      e0 = err_cnt;
      wq.push_back(16'h0001);
      mdl[0] = 8'h01;
      send(16'h8001, 16, 1'b1, rd, oe_ok);
      check("post_rst_regs", 64'(regs_flat), 64'(mdl_flat()));
      check("post_rst_err", 64'(err_cnt - e0), 64'd0);

      tick(4);
      check("wq_drained", 64'(wq.size()), 64'd0);
      check("rdq_drained", 64'(rdq.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_regfile_periph.md
Name: spi_regfile_periph

Overview:
Parametrised SPI (mode 0) peripheral owning a bank of NUM_REGS control registers of DATA_W bits.
Supports both write and read-back over CIPO, out-of-range address handling, and aborted-frame detection.
Sits between the chip-level SPI pins and the output-enable, PWM-enable and duty-cycle consumers.
The flat register bus feeds those consumers directly.

Parameters:
NUM_REGS, 5, number of implemented registers (addresses 0..NUM_REGS-1)
ADDR_W, 7, address field width in the frame
DATA_W, 8, register and data field width
SYNC_STAGES, 2, flip-flop synchroniser depth on SCLK/COPI/nCS (min 2)

Ports:
clk  in  1  system clock; must be at least 8x SCLK frequency
rst_n  in  1  reset
sclk  in  1  SPI clock, async to clk
copi  in  1  controller-out data, async
ncs  in  1  active-low chip select, async
cipo  out  1  peripheral-out read data; 0 when cipo_oe=0
cipo_oe  out  1  output enable for pad driver
regs_flat  out  NUM_REGS*DATA_W  register i at bits [i*DATA_W +: DATA_W]
wr_strobe  out  NUM_REGS  one-clk pulse on bit i when register i is updated
frame_err  out  1  one-clk pulse on aborted or over-length frame

Behaviour:
- Reset and clocking: reset rst_n, asynchronous, active-low; clock clk. All logic is in the clk domain.
- Synchronisers: SCLK/COPI/nCS pass through SYNC_STAGES flops. Synchroniser reset values are sclk 0, copi 0, ncs 1.
- Edge detection: rising/falling edges of SCLK and nCS are detected against a one-flop delayed copy of the synchronised signal.
- Reset values: all registers 0, cipo 0, cipo_oe 0, wr_strobe 0, frame_err 0, FSM in IDLE.
- Frame format (MSB first, sampled on SCLK rise): bit 0 = R/W (1 = write), then ADDR_W address bits, then DATA_W data bits. Frame length is 1+ADDR_W+DATA_W (16 by default).
- FSM states: IDLE, ADDR, DATA, DONE.
  - IDLE -> ADDR on nCS fall; bit counter cleared.
  - ADDR: shifts R/W+address. On the rising edge capturing the last address bit -> DATA.
  - On that same ADDR -> DATA edge, for a read: load the read shift register with reg[addr], or 0 if addr >= NUM_REGS.
  - DATA: a write shifts COPI in. A read shifts the read register left one clk after each detected SCLK rise.
  - On the last data bit -> DONE.
  - DONE: ignores further SCLK edges. Returns to IDLE on nCS rise.
- Write commit:
  - Happens the clk after the rising edge detecting the final data bit, only if addr < NUM_REGS.
  - Updates reg[addr] and pulses wr_strobe[addr] for 1 clk.
  - Out-of-range write: no update, no strobe, no error.
- Read path:
  - cipo = MSB of the read shift register.
  - cipo_oe = 1 only in DATA or DONE of a read frame while synchronised nCS is low.
  - The first data bit is valid on cipo within 2 clk of the last address-bit SCLK rise. It is therefore stable before the controller's next rising edge.
- Abort: nCS rise in ADDR or DATA -> pulse frame_err, discard the frame, no register change, go to IDLE.
- Over-length: any SCLK rise seen in DONE pulses frame_err once per frame. The committed write stays.
- Simultaneous events: an nCS rise in the same clk as the final-bit SCLK rise counts as complete. The commit wins and frame_err is not raised.
- SCLK edges while nCS is high are ignored.
- Reset mid-frame: FSM to IDLE and all registers to 0 immediately. The frame is lost without error; the next nCS fall starts a fresh frame.
- Register outputs change only on commit or reset; there are no glitches while shifting.

Test Plan:
- Write 0xA5 to addr 0, then 0x3C to addr 4 (frames 0x80A5, 0x843C) -> regs_flat[7:0]=0xA5 and [39:32]=0x3C. wr_strobe pulses bit 0 then bit 4, one clk each. Other registers stay 0.
- After the writes, read addr 4 (frame 0x04xx, COPI data don't-care) -> cipo shifts 0x3C MSB-first and cipo_oe=1 during the data phase. No register changes and wr_strobe stays 0.
- Write addr 9 data 0xFF, then read addr 9 -> no register changes, no strobe, read returns 0x00, frame_err stays 0.
- Raise nCS after 10 SCLK bits of write 0x82FF -> frame_err pulses 1 clk, reg2 keeps its prior value, and the next full frame 0x8211 sets reg2=0x11.
- Send 20 SCLK pulses with leading 16 bits = 0x8155 -> reg1=0x55, frame_err pulses exactly once, the extra 4 bits are ignored.
- Assert rst_n low after 12 bits of 0x8077 -> all regs 0 and cipo_oe 0. After release, frame 0x8001 sets reg0=0x01.
